button_pulse_array: RTL and testbench

Multi-channel push-button conditioner for the lab boards: synchronizes, debounces and edge-detects N raw button inputs. Per channel it produces single-cycle press and release pulses, a long-press pulse and an optional auto-repeat pulse train. All timing is in ticks of a shared timebase enable. It sits between the board pins and the FSM/datapath blocks and replaces per-button debounce/one-pulse pairs.

---
 rtl/button_pulse_array_if.sv | 29 ++
 rtl/button_pulse_array.sv | 138 +++++++++++++
 tb/tb_button_pulse_array.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_pulse_array_if.sv
// Button conditioner bus: the timebase tick, the raw pins and the repeat enables
// go in; the debounced level and the four pulse outputs come back.
// Ports (per modport):
//   master: drives tick, pb_raw, repeat_en; reads level, press, release_pulse,
//           long_press, rep
//   slave : the conditioner itself (opposite directions)
// release_pulse carries the debounced-falling-edge pulse ("release" is a reserved word).
interface button_pulse_array_if #(
  parameter int N = 4
);
  logic         tick;
  logic [N-1:0] pb_raw;
  logic [N-1:0] repeat_en;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] release_pulse;
  logic [N-1:0] long_press;
  logic [N-1:0] rep;

  modport master (
    output tick, pb_raw, repeat_en,
    input  level, press, release_pulse, long_press, rep
  );

  modport slave (
    input  tick, pb_raw, repeat_en,
    output level, press, release_pulse, long_press, rep
  );
endinterface

// File: rtl/button_pulse_array.sv
// Multi-channel push-button conditioner. Each channel is synchronized, debounced
// on timebase ticks, edge-detected into press/release pulses, and timed for a
// long-press pulse and an optional auto-repeat pulse train.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - button_pulse_array_if.slave (tick, pb_raw, repeat_en in;
//          level, press, release_pulse, long_press, rep out)
module button_pulse_array #(
  parameter int N            = 4,
  parameter int DEBOUNCE_LEN = 4,
  parameter int HOLD_TICKS   = 8,
  parameter int REPEAT_TICKS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  button_pulse_array_if.slave   bus
);

  localparam int MAX_TICKS = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } state_t;

  logic [N-1:0]              sync1;
  logic [N-1:0]              sync2;
  logic [N-1:0]              level_d;
  // Only the previous DEBOUNCE_LEN-1 tick samples are stored; the current
  // synchronized input completes the DEBOUNCE_LEN-sample window.
  logic [DEBOUNCE_LEN-2:0]   hist   [N];
  logic [DEBOUNCE_LEN-1:0]   window [N];
  logic [CW-1:0]             cnt    [N];
  state_t                    state  [N];

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      window[i] = {hist[i], sync2[i]};
    end
  end

  // Synchronizer, debounce and edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1             <= '0;
      sync2             <= '0;
      level_d           <= '0;
      bus.level         <= '0;
      bus.press         <= '0;
      bus.release_pulse <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        hist[i] <= '0;
      end
    end else begin
      sync1             <= bus.pb_raw;
      sync2             <= sync1;
      level_d           <= bus.level;
      bus.press         <= bus.level & ~level_d;
      bus.release_pulse <= ~bus.level & level_d;
      if (bus.tick) begin
        for (int unsigned i = 0; i < N; i++) begin
          hist[i] <= window[i][DEBOUNCE_LEN-2:0];
          if (&window[i]) begin
            bus.level[i] <= 1'b1;
          end else if (~|window[i]) begin
            bus.level[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Hold / repeat FSM per channel; it looks at the registered level, so it
  // enters PRESSED on the same edge the press pulse is raised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.long_press <= '0;
      bus.rep        <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      bus.long_press <= '0;
      bus.rep        <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        case (state[i])
          IDLE: begin
            if (bus.level[i]) begin
              state[i] <= PRESSED;
              cnt[i]   <= '0;
            end
          end
          PRESSED: begin
            if (!bus.level[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (bus.tick) begin
              if (cnt[i] == HOLD_LAST) begin
                bus.long_press[i] <= 1'b1;
                state[i]          <= HELD;
                cnt[i]            <= '0;
              end else begin
                cnt[i] <= cnt[i] + 1'b1;
              end
            end
          end
          HELD: begin
            if (!bus.level[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (!bus.repeat_en[i]) begin
              cnt[i] <= '0;
            end else if (bus.tick) begin
              if (cnt[i] == REP_LAST) begin
                bus.rep[i] <= 1'b1;
                cnt[i]     <= '0;
              end else begin
                cnt[i] <= cnt[i] + 1'b1;
              end
            end
          end
          default: begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_pulse_array.sv
// Bench for button_pulse_array: a cycle model of the button behaviour is checked
// against the outputs on every clock, with table-driven press scenarios, a few
// hand-written corner sequences and a randomized soak.
module tb_button_pulse_array;
  localparam int N  = 4;
  localparam int DL = 4;
  localparam int HT = 8;
  localparam int RT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  button_pulse_array_if #(.N(N)) bus ();

  button_pulse_array #(
    .N(N), .DEBOUNCE_LEN(DL), .HOLD_TICKS(HT), .REPEAT_TICKS(RT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors    = 0;
  int miscompares = 0;
  int tick_mode  = 0;
  int tick_div   = 0;
  bit last_tick;
  int cnt_press [N];
  int cnt_rel   [N];
  int cnt_long  [N];
  int cnt_rep   [N];

  // Reference model: sync delay line, run-length debounce, ticks-held timing.
  bit m_s1 [N];
  bit m_s2 [N];
  bit m_run_val [N];
  int m_run [N];
  bit m_lvl [N];
  bit m_lvl_d [N];
  bit m_active [N];
  bit m_long_done [N];
  int m_held [N];
  int m_rep_ticks [N];
  logic [N-1:0] e_lvl, e_press, e_rel, e_long, e_rep;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_run_val[i] = 0; m_run[i] = DL - 1;
      m_lvl[i] = 0; m_lvl_d[i] = 0; m_active[i] = 0; m_long_done[i] = 0;
      m_held[i] = 0; m_rep_ticks[i] = 0;
    end
    e_lvl = '0; e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
  endfunction

  function automatic void model_adv(input logic [N-1:0] raw, input logic [N-1:0] ren,
                                    input logic tk);
    for (int i = 0; i < N; i++) begin
      bit s_old = m_s2[i];
      bit lv    = m_lvl[i];
      e_press[i] = lv & !m_lvl_d[i];
      e_rel[i]   = !lv & m_lvl_d[i];
      m_lvl_d[i] = lv;
      e_long[i]  = 1'b0;
      e_rep[i]   = 1'b0;
      if (!lv) begin
        m_active[i] = 0;
        m_long_done[i] = 0;
      end else if (!m_active[i]) begin
        m_active[i] = 1;
        m_held[i] = 0;
      end else if (!m_long_done[i]) begin
        if (tk) m_held[i]++;
        if (m_held[i] == HT) begin
          e_long[i] = 1'b1;
          m_long_done[i] = 1;
          m_rep_ticks[i] = 0;
        end
      end else begin
        if (!ren[i]) m_rep_ticks[i] = 0;
        else if (tk) m_rep_ticks[i]++;
        if (m_rep_ticks[i] == RT) begin
          e_rep[i] = 1'b1;
          m_rep_ticks[i] = 0;
        end
      end
      if (tk) begin
        if (s_old == m_run_val[i]) begin
          if (m_run[i] < DL) m_run[i]++;
        end else begin
          m_run_val[i] = s_old;
          m_run[i] = 1;
        end
        if (m_run[i] >= DL) m_lvl[i] = m_run_val[i];
      end
      e_lvl[i] = m_lvl[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_outs();
    return {12'd0, bus.level, bus.press, bus.release_pulse, bus.long_press, bus.rep};
  endfunction

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      cnt_press[i] = 0; cnt_rel[i] = 0; cnt_long[i] = 0; cnt_rep[i] = 0;
    end
  endtask

  // One clock: advance the model with the inputs that were present at the
  // posedge just passed, compare, tally pulses, then pick the next tick.
  task automatic step();
    @(negedge clk);
    last_tick = bus.tick;
    if (rst) model_reset();
    else model_adv(bus.pb_raw, bus.repeat_en, bus.tick);
    check("cycle_outputs", dut_outs(), {12'd0, e_lvl, e_press, e_rel, e_long, e_rep});
    for (int i = 0; i < N; i++) begin
      cnt_press[i] += int'(bus.press[i]);
      cnt_rel[i]   += int'(bus.release_pulse[i]);
      cnt_long[i]  += int'(bus.long_press[i]);
      cnt_rep[i]   += int'(bus.rep[i]);
    end
    case (tick_mode)
      0: begin
        bus.tick = (tick_div == 3);
        tick_div = (tick_div + 1) % 4;
      end
      1: bus.tick = ($urandom_range(0, 2) == 0);
      default: bus.tick = 1'b1;
    endcase
  endtask

  task automatic wait_tick();
    do step(); while (!last_tick);
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) wait_tick();
  endtask

  typedef struct {
    int ch;
    int bounce;   // single-tick toggles before the stable high
    int hold;     // ticks the raw input stays stably high
    bit ren;
    int x_press, x_rel, x_long, x_rep;
  } entry_t;

  entry_t tbl[$];

  initial begin
    // hold = R gives R ticks seen by the hold timer (4 debounce ticks in, 4 out)
    tbl.push_back('{0, 0,  6, 1'b0, 1, 1, 0, 0});  // clean press
    tbl.push_back('{1, 10, 6, 1'b0, 1, 1, 0, 0});  // bounce then press
    tbl.push_back('{2, 0, 20, 1'b1, 1, 1, 1, 4});  // long + reps at 11,14,17,20
    tbl.push_back('{2, 0, 20, 1'b0, 1, 1, 1, 0});  // long, repeat disabled
    tbl.push_back('{3, 0,  7, 1'b1, 1, 1, 0, 0});  // one tick short of long
    tbl.push_back('{3, 0,  8, 1'b1, 1, 1, 1, 0});  // long on the falling edge
    tbl.push_back('{1, 0, 10, 1'b1, 1, 1, 1, 0});  // one tick short of a rep
    tbl.push_back('{1, 0, 11, 1'b1, 1, 1, 1, 1});  // first rep
    tbl.push_back('{0, 0,  3, 1'b0, 0, 0, 0, 0});  // too short to debounce
    tbl.push_back('{0, 0,  4, 1'b0, 1, 1, 0, 0});  // minimum accepted press
    tbl.push_back('{0, 3,  2, 1'b0, 0, 0, 0, 0});  // bounce + short: no change

    rst = 1'b1;
    bus.tick = 1'b0;
    bus.pb_raw = '0;
    bus.repeat_en = '0;
    model_reset();
    clear_counts();

    // ---- Reset: async clear mid-operation, then fresh debounce latency ----
    tick_mode = 2;
    repeat (3) step();
    rst = 1'b0;
    bus.pb_raw = 4'hF;
    bus.repeat_en = 4'hF;
    repeat (25) step();
    rst = 1'b1;
    #1;
    check("reset_async_clear", dut_outs(), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    clear_counts();
    begin
      int n;
      n = 0;
      while (n < 20) begin
        step();
        n++;
        if (bus.press[0]) break;
      end
      check("reset_press_latency", n, 7);
    end
    repeat (6) step();
    check("reset_no_release", cnt_rel[0] + cnt_rel[1] + cnt_rel[2] + cnt_rel[3], 0);
    check("reset_fresh_press", cnt_press[3], 1);
    bus.pb_raw = '0;
    bus.repeat_en = '0;
    tick_mode = 0;
    wait_ticks(10);

    // ---- Table-driven press scenarios ----
    foreach (tbl[t]) begin
      entry_t e;
      int others;
      e = tbl[t];
      clear_counts();
      bus.repeat_en = '0;
      bus.repeat_en[e.ch] = e.ren;
      wait_tick();
      for (int k = 0; k < e.bounce; k++) begin
        bus.pb_raw[e.ch] = ~bus.pb_raw[e.ch];
        wait_tick();
      end
      bus.pb_raw[e.ch] = 1'b1;
      wait_ticks(e.hold);
      bus.pb_raw[e.ch] = 1'b0;
      wait_ticks(8);
      repeat (4) step();
      check($sformatf("tbl%0d_press", t), cnt_press[e.ch], e.x_press);
      check($sformatf("tbl%0d_release", t), cnt_rel[e.ch], e.x_rel);
      check($sformatf("tbl%0d_long", t), cnt_long[e.ch], e.x_long);
      check($sformatf("tbl%0d_rep", t), cnt_rep[e.ch], e.x_rep);
      others = 0;
      for (int j = 0; j < N; j++)
        if (j != e.ch) others += cnt_press[j] + cnt_rel[j] + cnt_long[j] + cnt_rep[j];
      check($sformatf("tbl%0d_other_channels", t), others, 0);
    end
    bus.repeat_en = '0;

    // ---- Bounce on ch1: level only after 4 stable ticks, no release ----
    clear_counts();
    wait_tick();
    begin
      logic seen;
      int n;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
        bus.pb_raw[1] = ~bus.pb_raw[1];
        wait_tick();
        seen |= bus.level[1];
      end
      check("bounce_level_stays_low", seen, 1'b0);
      bus.pb_raw[1] = 1'b1;
      n = 0;
      while (n < 10) begin
        wait_tick();
        n++;
        if (bus.level[1]) break;
      end
      check("bounce_stable_ticks_to_level", n, 4);
    end
    wait_ticks(3);
    check("bounce_one_press", cnt_press[1], 1);
    check("bounce_no_release", cnt_rel[1], 0);
    bus.pb_raw[1] = 1'b0;
    wait_ticks(10);

    // ---- Multi-channel: ch0 clean and ch3 bouncing from the same clock ----
    clear_counts();
    wait_tick();
    bus.pb_raw[0] = 1'b1;
    bus.pb_raw[3] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_tick();
      bus.pb_raw[3] = ~bus.pb_raw[3];
    end
    bus.pb_raw[3] = 1'b1;
    wait_ticks(10);
    check("multi_level", bus.level, 4'b1001);
    check("multi_press_ch0", cnt_press[0], 1);
    check("multi_press_ch3", cnt_press[3], 1);
    check("multi_long_ch0_once", cnt_long[0], 1);
    bus.pb_raw = '0;
    wait_ticks(10);
    check("multi_release_ch0", cnt_rel[0], 1);
    check("multi_release_ch3", cnt_rel[3], 1);
    check("multi_idle_ch1_ch2",
          cnt_press[1] + cnt_press[2] + cnt_rel[1] + cnt_rel[2] + cnt_long[1] + cnt_long[2], 0);

    // ---- Randomized soak against the model ----
    for (int seg = 0; seg < 6; seg++) begin
      int flip_pct;
      tick_mode = seg % 3;
      flip_pct = (seg < 3) ? 2 : 25;
      for (int c = 0; c < 500; c++) begin
        step();
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 99) < flip_pct) bus.pb_raw[i] = ~bus.pb_raw[i];
          if ($urandom_range(0, 99) < 3) bus.repeat_en[i] = ~bus.repeat_en[i];
        end
        if (rst) rst = 1'b0;
        else if ($urandom_range(0, 999) == 0) rst = 1'b1;
      end
    end
    rst = 1'b0;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
